// File: rtl/fir_eq_pkg.sv
// Shared types, defaults and output rounding for the equalizer FIR datapath.
package fir_eq_pkg;

  localparam int unsigned WD_IN_DEF   = 24;
  localparam int unsigned WD_OUT_DEF  = 24;
  localparam int unsigned WD_COEF_DEF = 18;
  localparam int unsigned NTAPS_DEF   = 64;
  localparam int unsigned NUM_CH_DEF  = 2;

  // Wide enough to hold any accumulator this block is realistically built with.
  localparam int unsigned ACC_MAX_W = 64;

  typedef logic signed [ACC_MAX_W-1:0]   acc_t;
  typedef logic signed [WD_COEF_DEF-1:0] coef_t;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} fsm_e;

  // Round half-up at bit frac-1, drop frac bits, clamp to a signed wd_out range.
  function automatic acc_t sat_round(input acc_t acc, input int unsigned frac,
                                     input int unsigned wd_out);
    acc_t r;
    acc_t hi;
    acc_t lo;
    r  = (acc + (acc_t'(1) <<< (frac - 1))) >>> frac;
    hi = (acc_t'(1) <<< (wd_out - 1)) - acc_t'(1);
    lo = ~hi;
    if (r > hi)      sat_round = hi;
    else if (r < lo) sat_round = lo;
    else             sat_round = r;
  endfunction

endpackage

// File: rtl/fir_tdm_ram.sv
// Simple dual-port RAM, one write and one registered read port.
module fir_tdm_ram #(
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned WIDTH      = 24,
  parameter bit          CLR_ON_RST = 1'b0,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port (optionally cleared by reset) and registered read; a read
  // issued the cycle after a write to the same address returns the new data.
  always_ff @(posedge clk) begin
    if (CLR_ON_RST && reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[AW'(i)] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_tdm_eq.sv
// Time-multiplexed multi-channel FIR: one shared MAC walks NTAPS taps per sample,
// per-channel delay lines, double-banked runtime-swappable coefficients.
module fir_tdm_eq
  import fir_eq_pkg::*;
#(
  parameter int unsigned WD_IN    = WD_IN_DEF,
  parameter int unsigned WD_OUT   = WD_OUT_DEF,
  parameter int unsigned WD_COEF  = WD_COEF_DEF,
  parameter int unsigned NTAPS    = NTAPS_DEF,
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned AW      = $clog2(NUM_CH * NTAPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [WD_IN-1:0]   data_in,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_ch,
  output logic [WD_OUT-1:0]  data_out,
  input  logic               coef_we,
  input  logic [AW-1:0]      coef_addr,
  input  logic [WD_COEF-1:0] coef_data,
  input  logic               coef_swap,
  output logic               swap_pend
);

  localparam int unsigned TAP_N  = NUM_CH * NTAPS;
  localparam int unsigned CF_AW  = AW + 1;
  localparam int unsigned PTR_W  = $clog2(NTAPS);
  localparam int unsigned K_W    = $clog2(NTAPS + 1);
  localparam int unsigned PROD_W = WD_IN + WD_COEF;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NTAPS);

  fsm_e                     state;
  logic [K_W-1:0]           tap;
  logic [PTR_W-1:0]         rd_idx;
  logic [PTR_W-1:0]         wr_ptr [NUM_CH];
  logic [CH_W-1:0]          ch_q;
  logic signed [ACC_W-1:0]  acc;
  logic                     prod_vld;
  logic                     bank;

  logic                     accept;
  logic                     swap_now;
  logic                     wr_bank;
  logic [K_W-1:0]           rd_tap;
  logic [AW-1:0]            dl_waddr;
  logic [AW-1:0]            dl_raddr;
  logic [CF_AW-1:0]         cf_waddr;
  logic [CF_AW-1:0]         cf_raddr;
  logic [WD_IN-1:0]         dl_rdata;
  logic [WD_COEF-1:0]       cf_rdata;
  logic signed [PROD_W-1:0] prod;

  // Handshake, swap timing and bank selection for writes (the swap cycle writes the old active bank).
  assign accept   = in_valid & in_ready;
  assign swap_now = (state == IDLE) & swap_pend;
  assign wr_bank  = swap_now ? bank : ~bank;
  assign rd_tap   = (tap < K_W'(NTAPS)) ? tap : '0;

  // Flat RAM addresses: channel-major, coefficient bank above all channels.
  assign dl_waddr = AW'(in_ch) * AW'(NTAPS) + AW'(wr_ptr[in_ch]);
  assign dl_raddr = AW'(ch_q) * AW'(NTAPS) + AW'(rd_idx);
  assign cf_waddr = CF_AW'(wr_bank) * CF_AW'(TAP_N) + CF_AW'(coef_addr);
  assign cf_raddr = CF_AW'(bank) * CF_AW'(TAP_N) + CF_AW'(ch_q) * CF_AW'(NTAPS)
                  + CF_AW'(rd_tap);

  assign prod = PROD_W'($signed(dl_rdata)) * PROD_W'($signed(cf_rdata));

  fir_tdm_ram #(.DEPTH(TAP_N), .WIDTH(WD_IN), .CLR_ON_RST(1'b1)) u_dline (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr (dl_waddr),
    .wdata (data_in),
    .raddr (dl_raddr),
    .rdata (dl_rdata)
  );

  fir_tdm_ram #(.DEPTH(2 * TAP_N), .WIDTH(WD_COEF), .CLR_ON_RST(1'b0)) u_coef (
    .clk   (clk),
    .reset (reset),
    .we    (coef_we),
    .waddr (cf_waddr),
    .wdata (coef_data),
    .raddr (cf_raddr),
    .rdata (cf_rdata)
  );

  // Control FSM, MAC pipeline, bank swap and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tap       <= '0;
      rd_idx    <= '0;
      wr_ptr    <= '{default: '0};
      ch_q      <= '0;
      acc       <= '0;
      prod_vld  <= 1'b0;
      bank      <= 1'b0;
      swap_pend <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_ch    <= '0;
      data_out  <= '0;
    end else begin
      out_valid <= 1'b0;
      prod_vld  <= 1'b0;

      if (swap_now) begin
        bank      <= ~bank;
        swap_pend <= 1'b0;
      end else if (coef_swap) begin
        swap_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= '0;
            ch_q     <= in_ch;
            rd_idx   <= wr_ptr[in_ch];
            tap      <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          if (prod_vld) acc <= acc + ACC_W'(prod);
          if (tap == K_W'(NTAPS)) begin
            state <= ROUND;
          end else begin
            prod_vld <= 1'b1;
            tap      <= tap + 1'b1;
            rd_idx   <= (rd_idx == '0) ? PTR_W'(NTAPS - 1) : rd_idx - 1'b1;
          end
        end
        ROUND: begin
          data_out  <= WD_OUT'(sat_round(acc_t'(acc), WD_COEF - 1, WD_OUT));
          out_ch    <= ch_q;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          wr_ptr[ch_q] <= (wr_ptr[ch_q] == PTR_W'(NTAPS - 1)) ? '0 : wr_ptr[ch_q] + 1'b1;
          in_ready     <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
